bytewrite_tdp_ram_mc: RTL and testbench

Single-clock true dual-port RAM with per-byte write enables, parametrised byte width, byte count and depth, and a run-time selectable per-port read mode (write-first, read-first, no-change). Successor to our fixed write-first byte-write TDP RAM; adds port enables, defined same-address collision arbitration, a sticky collision flag and a saturating collision counter. Sits beside datapath blocks as a shared scratch/packet buffer. Maps to block RAM: the storage array has no reset.

---
 rtl/bytewrite_ram_pkg.sv | 36 +++
 rtl/bytewrite_ram_rdport.sv | 56 +++++
 rtl/bytewrite_tdp_ram_mc.sv | 93 +++++++++
 tb/tb_bytewrite_tdp_ram_mc.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bytewrite_ram_pkg.sv
// rtl/bytewrite_ram_pkg.sv - read-mode type, size defaults and byte-merge helper for the byte-write TDP RAM
package bytewrite_ram_pkg;

  typedef enum logic [1:0] {
    WR_FIRST  = 2'd0,
    RD_FIRST  = 2'd1,
    NO_CHANGE = 2'd2,
    MODE_RSVD = 2'd3
  } rd_mode_e;

  localparam int AW_DEF = 5;
  localparam int NB_DEF = 4;
  localparam int BW_DEF = 8;

  localparam int NB_MAX = 16;
  localparam int BW_MAX = 9;
  localparam int DW_MAX = NB_MAX * BW_MAX;

  // Works on the widest legal word so one helper serves every NB/BW; callers cast in and out.
  function automatic logic [DW_MAX-1:0] byte_merge(
    input logic [DW_MAX-1:0] old_w,
    input logic [DW_MAX-1:0] new_w,
    input logic [NB_MAX-1:0] we,
    input int                bw
  );
    logic [DW_MAX-1:0] lane_ones;
    logic [DW_MAX-1:0] mask;
    lane_ones = (DW_MAX'(1) << bw) - DW_MAX'(1);
    mask      = '0;
    for (int l = 0; l < NB_MAX; l++) begin
      if (we[l]) mask = mask | (lane_ones << (l * bw));
    end
    return (old_w & ~mask) | (new_w & mask);
  endfunction

endpackage

// File: rtl/bytewrite_ram_rdport.sv
// rtl/bytewrite_ram_rdport.sv - per-port read-mode select, NO_CHANGE hold and output stage
// RAM_OUTREG_EN adds a second output register enabled by the port enable delayed one cycle.
module bytewrite_ram_rdport
  import bytewrite_ram_pkg::*;
#(
  parameter int NB = 4,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] i_stored,
  input  logic [DW-1:0] i_merged,
  input  logic          i_en,
  input  logic [NB-1:0] i_we,
  input  rd_mode_e      i_mode,
  output logic [DW-1:0] o_dout
);

  logic          w_hold;
  logic          w_load;
  logic [DW-1:0] w_rd_data;
  logic [DW-1:0] r_stage1;

  assign w_hold    = (i_mode == NO_CHANGE) && (i_we != '0);
  assign w_load    = i_en && !w_hold;
  // The reserved mode falls through to the write-first path.
  assign w_rd_data = ((i_mode == RD_FIRST) || (i_mode == NO_CHANGE)) ? i_stored : i_merged;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stage1 <= '0;
    end else if (w_load) begin
      r_stage1 <= w_rd_data;
    end
  end

`ifdef RAM_OUTREG_EN
  logic          r_en_d;
  logic [DW-1:0] r_stage2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en_d   <= 1'b0;
      r_stage2 <= '0;
    end else begin
      r_en_d <= i_en;
      if (r_en_d) r_stage2 <= r_stage1;
    end
  end

  assign o_dout = r_stage2;
`else
  assign o_dout = r_stage1;
`endif

endmodule

// File: rtl/bytewrite_tdp_ram_mc.sv
// rtl/bytewrite_tdp_ram_mc.sv - byte-write true dual-port RAM with collision arbitration and counter
// RAM_OUTREG_EN selects the two-cycle read latency build of the read ports.
module bytewrite_tdp_ram_mc
  import bytewrite_ram_pkg::*;
#(
  parameter  int AW = AW_DEF,
  parameter  int NB = NB_DEF,
  parameter  int BW = BW_DEF,
  parameter  int CW = 16,
  localparam int DW = NB * BW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ena,
  input  logic [NB-1:0] wea,
  input  logic [AW-1:0] addra,
  input  logic [DW-1:0] dina,
  input  logic [1:0]    modea,
  output logic [DW-1:0] douta,
  input  logic          enb,
  input  logic [NB-1:0] web,
  input  logic [AW-1:0] addrb,
  input  logic [DW-1:0] dinb,
  input  logic [1:0]    modeb,
  output logic [DW-1:0] doutb,
  output logic          coll_flag,
  output logic [CW-1:0] coll_cnt,
  input  logic          coll_clr
);

  logic [DW-1:0] r_mem [2**AW];
  logic [DW-1:0] w_old_a;
  logic [DW-1:0] w_old_b;
  logic [DW-1:0] w_merged_a;
  logic [DW-1:0] w_merged_b;
  logic          w_coll;
  logic          r_coll_flag;
  logic [CW-1:0] r_coll_cnt;

  // Port A's lane writes are issued last, so A owns any lane both ports write.
  always_ff @(posedge clk) begin
    for (int l = 0; l < NB; l++) begin
      if (enb && web[l]) r_mem[addrb][l*BW +: BW] <= dinb[l*BW +: BW];
      if (ena && wea[l]) r_mem[addra][l*BW +: BW] <= dina[l*BW +: BW];
    end
  end

  assign w_old_a    = r_mem[addra];
  assign w_old_b    = r_mem[addrb];
  assign w_merged_a = DW'(byte_merge(DW_MAX'(w_old_a), DW_MAX'(dina), NB_MAX'(wea), BW));
  assign w_merged_b = DW'(byte_merge(DW_MAX'(w_old_b), DW_MAX'(dinb), NB_MAX'(web), BW));

  bytewrite_ram_rdport #(.NB(NB), .DW(DW)) u_rdport_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_stored (w_old_a),
    .i_merged (w_merged_a),
    .i_en     (ena),
    .i_we     (wea),
    .i_mode   (rd_mode_e'(modea)),
    .o_dout   (douta)
  );

  bytewrite_ram_rdport #(.NB(NB), .DW(DW)) u_rdport_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_stored (w_old_b),
    .i_merged (w_merged_b),
    .i_en     (enb),
    .i_we     (web),
    .i_mode   (rd_mode_e'(modeb)),
    .o_dout   (doutb)
  );

  assign w_coll = ena && enb && (addra == addrb) && ((wea | web) != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_coll_flag <= 1'b0;
      r_coll_cnt  <= '0;
    end else if (coll_clr) begin
      r_coll_flag <= 1'b0;
      r_coll_cnt  <= '0;
    end else if (w_coll) begin
      r_coll_flag <= 1'b1;
      if (r_coll_cnt != '1) r_coll_cnt <= r_coll_cnt + CW'(1);
    end
  end

  assign coll_flag = r_coll_flag;
  assign coll_cnt  = r_coll_cnt;

endmodule

// File: tb/tb_bytewrite_tdp_ram_mc.sv
// tb/tb_bytewrite_tdp_ram_mc.sv - self-checking bench for bytewrite_tdp_ram_mc with a behavioural model
module tb_bytewrite_tdp_ram_mc;

  localparam int AW = 5;
  localparam int NB = 4;
  localparam int BW = 8;
  localparam int DW = NB * BW;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;
`ifdef RAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena, enb, coll_clr;
  logic [NB-1:0] wea, web;
  logic [AW-1:0] addra, addrb;
  logic [DW-1:0] dina, dinb;
  logic [1:0]    modea, modeb;
  logic [DW-1:0] douta, doutb;
  logic          coll_flag;
  logic [CW-1:0] coll_cnt;

  always #5 clk = ~clk;

  bytewrite_tdp_ram_mc #(.AW(AW), .NB(NB), .BW(BW), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .wea       (wea),
    .addra     (addra),
    .dina      (dina),
    .modea     (modea),
    .douta     (douta),
    .enb       (enb),
    .web       (web),
    .addrb     (addrb),
    .dinb      (dinb),
    .modeb     (modeb),
    .doutb     (doutb),
    .coll_flag (coll_flag),
    .coll_cnt  (coll_cnt),
    .coll_clr  (coll_clr)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] m_mem [2**AW];
  logic [DW-1:0] m_douta = '0, m_doutb = '0, m_s1a = '0, m_s1b = '0;
  logic          m_ena_d = 1'b0, m_enb_d = 1'b0, m_flag = 1'b0;
  int            m_cnt = 0;

  logic [DW-1:0] mode_exp [3];
  logic [DW-1:0] cap [3];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mergew(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                           input logic [NB-1:0] we);
    logic [DW-1:0] r;
    r = o;
    for (int i = 0; i < NB; i++) if (we[i]) r[i*BW +: BW] = n[i*BW +: BW];
    return r;
  endfunction

  function automatic logic [DW-1:0] next_read(input logic en, input logic [1:0] mode,
                                              input logic [NB-1:0] we, input logic [DW-1:0] old,
                                              input logic [DW-1:0] din, input logic [DW-1:0] prev);
    if (!en) return prev;
    case (mode)
      2'd1:    return old;
      2'd2:    return (we != '0) ? prev : old;
      default: return mergew(old, din, we);
    endcase
  endfunction

  task automatic model_edge();
    logic [DW-1:0] s1a, s1b;
    s1a = next_read(ena, modea, wea, m_mem[addra], dina, m_s1a);
    s1b = next_read(enb, modeb, web, m_mem[addrb], dinb, m_s1b);
    if (LAT == 1) begin
      m_douta = s1a;
      m_doutb = s1b;
    end else begin
      if (m_ena_d) m_douta = m_s1a;
      if (m_enb_d) m_doutb = m_s1b;
    end
    m_s1a = s1a;
    m_s1b = s1b;
    m_ena_d = ena;
    m_enb_d = enb;
    if (enb) m_mem[addrb] = mergew(m_mem[addrb], dinb, web);
    if (ena) m_mem[addra] = mergew(m_mem[addra], dina, wea);
    if (coll_clr) begin
      m_flag = 1'b0;
      m_cnt  = 0;
    end else if (ena && enb && addra == addrb && (wea != '0 || web != '0)) begin
      m_flag = 1'b1;
      if (m_cnt < CNT_MAX) m_cnt++;
    end
  endtask

  task automatic model_reset();
    m_douta = '0; m_doutb = '0; m_s1a = '0; m_s1b = '0;
    m_ena_d = 1'b0; m_enb_d = 1'b0; m_flag = 1'b0; m_cnt = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("douta", douta, m_douta);
    check("doutb", doutb, m_doutb);
    check("coll_flag", coll_flag, m_flag);
    check("coll_cnt", coll_cnt, m_cnt);
  endtask

  task automatic idle();
    ena = 1'b0; enb = 1'b0; wea = '0; web = '0; coll_clr = 1'b0;
  endtask

  task automatic set_a(input logic en, input logic [NB-1:0] we, input logic [AW-1:0] ad,
                       input logic [DW-1:0] d, input logic [1:0] md);
    ena = en; wea = we; addra = ad; dina = d; modea = md;
  endtask

  task automatic set_b(input logic en, input logic [NB-1:0] we, input logic [AW-1:0] ad,
                       input logic [DW-1:0] d, input logic [1:0] md);
    enb = en; web = we; addrb = ad; dinb = d; modeb = md;
  endtask

  initial begin
    idle();
    set_a(1'b0, '0, '0, '0, 2'd0);
    set_b(1'b0, '0, '0, '0, 2'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_douta", douta, 0);
    check("rst_doutb", doutb, 0);
    check("rst_flag", coll_flag, 0);
    check("rst_cnt", coll_cnt, 0);
    rst_n = 1'b1;

    for (int a = 0; a < 2**AW; a++) begin
      idle(); set_a(1'b1, '1, AW'(a), $urandom, 2'd0); step();
    end

    mode_exp[0] = 32'h1122CCDD;
    mode_exp[1] = 32'h11223344;
    mode_exp[2] = 32'h66666666;
    for (int m = 0; m < 3; m++) begin
      idle(); set_a(1'b1, '1, 5'd6, 32'h66666666, 2'd0); step();
      idle(); set_a(1'b1, '1, 5'd5, 32'h11223344, 2'd0); step();
      idle(); set_a(1'b1, '0, 5'd6, '0, 2'd0); step();
      idle(); set_a(1'b1, 4'b0011, 5'd5, 32'hAABBCCDD, m[1:0]); step();
      idle(); repeat (LAT-1) step();
      check($sformatf("mode%0d_dout", m), douta, mode_exp[m]);
      set_a(1'b1, '0, 5'd5, '0, 2'd0); step();
      idle(); repeat (LAT-1) step();
      check($sformatf("mode%0d_after", m), douta, 32'h1122CCDD);
    end

    idle(); set_a(1'b1, '1, 5'd7, '0, 2'd0); step();
    idle(); set_a(1'b1, '1, 5'd7, 32'hDEADBEEF, 2'd0); set_b(1'b1, '0, 5'd7, '0, 2'd0); step();
    cap[0] = doutb;
    idle(); set_b(1'b1, '0, 5'd7, '0, 2'd1); step();
    cap[1] = doutb;
    idle(); step();
    cap[2] = doutb;
    check("xport_old", cap[LAT-1], 0);
    check("xport_new", cap[LAT], 32'hDEADBEEF);

    idle(); set_b(1'b1, '0, 5'd6, '0, 2'd0); step();
    idle(); addrb = 5'd5; repeat (LAT) step();
    check("enb_hold", doutb, 32'h66666666);

    idle(); set_a(1'b1, '1, 5'd9, '0, 2'd0); coll_clr = 1'b1; step();
    idle(); set_a(1'b1, 4'b1100, 5'd9, 32'h11111111, 2'd0);
    set_b(1'b1, 4'b0110, 5'd9, 32'h22222222, 2'd0); step();
    check("coll1_flag", coll_flag, 1);
    check("coll1_cnt", coll_cnt, 1);
    idle(); set_a(1'b1, '0, 5'd9, '0, 2'd0); set_b(1'b1, '0, 5'd9, '0, 2'd1); step();
    check("rdrd_no_coll", coll_cnt, 1);
    idle(); repeat (LAT-1) step();
    check("coll_mem9", douta, 32'h11112200);

    for (int i = 0; i < 20; i++) begin
      logic [AW-1:0] r;
      r = AW'($urandom);
      idle(); set_a(1'b1, NB'($urandom), r, $urandom, 2'($urandom));
      set_b(1'b1, NB'($urandom) | NB'(1), r, $urandom, 2'($urandom)); step();
    end
    check("sat_cnt", coll_cnt, 15);
    check("sat_flag", coll_flag, 1);
    idle(); set_a(1'b1, '1, 5'd4, $urandom, 2'd0); set_b(1'b1, '1, 5'd4, $urandom, 2'd0);
    coll_clr = 1'b1; step();
    check("clr_cnt", coll_cnt, 0);
    check("clr_flag", coll_flag, 0);

    for (int i = 0; i < 400; i++) begin
      ena = ($urandom_range(0, 3) != 0);
      enb = ($urandom_range(0, 3) != 0);
      addra = AW'($urandom_range(0, 3));
      addrb = AW'($urandom_range(0, 3));
      wea = ($urandom_range(0, 1) != 0) ? NB'($urandom) : '0;
      web = ($urandom_range(0, 1) != 0) ? NB'($urandom) : '0;
      dina = $urandom;
      dinb = $urandom;
      modea = 2'($urandom);
      modeb = 2'($urandom);
      coll_clr = ($urandom_range(0, 15) == 0);
      step();
    end

    idle(); set_a(1'b1, '1, 5'd3, 32'h0BADF00D, 2'd0); step();
    idle(); set_a(1'b1, '0, 5'd10, '0, 2'd0); set_b(1'b1, '1, 5'd10, 32'h5A5A5A5A, 2'd1); step();
    idle();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("arst_douta", douta, 0);
    check("arst_doutb", doutb, 0);
    check("arst_flag", coll_flag, 0);
    check("arst_cnt", coll_cnt, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle(); set_a(1'b1, '0, 5'd3, '0, 2'd0); step();
    idle(); repeat (LAT-1) step();
    check("rst_keep_mem", douta, 32'h0BADF00D);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
